// File: rtl/uart_calc_pkg.sv
// rtl/uart_calc_pkg.sv - ASCII constants, parser states and hex helpers for the UART calculator
package uart_calc_pkg;

  localparam logic [7:0] ASC_I     = 8'h49;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_S     = 8'h53;
  localparam logic [7:0] ASC_U     = 8'h55;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_STAR  = 8'h2A;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  // Digit states are consecutive so the parser can step through them by +1
  typedef enum logic [3:0] {
    ST_WAIT_I = 4'd0,
    ST_SP1    = 4'd1,
    ST_MODE   = 4'd2,
    ST_SP2    = 4'd3,
    ST_A0     = 4'd4,
    ST_A1     = 4'd5,
    ST_A2     = 4'd6,
    ST_A3     = 4'd7,
    ST_OP     = 4'd8,
    ST_B0     = 4'd9,
    ST_B1     = 4'd10,
    ST_B2     = 4'd11,
    ST_B3     = 4'd12,
    ST_EQ     = 4'd13
  } parse_state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } alu_op_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_nib_t;

  function automatic hex_nib_t hex2nib(input logic [7:0] c);
    hex_nib_t h;
    h.valid = 1'b1;
    h.nib   = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      h.nib = c[3:0];
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      h.nib = c[3:0] + 4'd9;
    end else begin
      h.valid = 1'b0;
    end
    return h;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = {4'h3, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

endpackage

// File: rtl/uart_calc_if.sv
// rtl/uart_calc_if.sv - Received-byte stream between the UART receiver and the command parser
interface uart_calc_if;
  logic [7:0] tdata;
  logic       tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input tdata, input tvalid);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: input synchronizer, mid-bit sampling, one-cycle byte strobe
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         rxd,
  uart_calc_if.master  rx_byte
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    byte_data;
  logic          byte_valid;

  assign rx_byte.tdata  = byte_data;
  assign rx_byte.tvalid = byte_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      rx_meta    <= rxd;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again by mid-bit was only a glitch
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_calc_top.sv
// rtl/uart_calc_top.sv - UART hex calculator: command parser, 32-bit ALU and hex result transmitter
module uart_calc_top
  import uart_calc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic rxd,
  output logic txd
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_calc_if rx_byte ();

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .n_rst   (n_rst),
    .rxd     (rxd),
    .rx_byte (rx_byte)
  );

  parse_state_e  pstate;
  logic          mode_signed;
  alu_op_e       op;
  logic [15:0]   opa;
  logic [15:0]   opb;
  logic [31:0]   result;

  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [3:0]    tx_byte_idx;
  logic [9:0]    tx_frame;

  hex_nib_t      rx_nib;
  logic [31:0]   ext_a;
  logic [31:0]   ext_b;
  logic [31:0]   alu_r;
  logic          tx_start;

  assign rx_nib   = hex2nib(rx_byte.tdata);
  assign tx_start = rx_byte.tvalid && !tx_busy && (pstate == ST_EQ) && (rx_byte.tdata == ASC_EQ);

  // The low 32 bits of a product of sign-extended operands equal the signed 16x16 product
  always_comb begin
    ext_a = mode_signed ? {{16{opa[15]}}, opa} : {16'h0000, opa};
    ext_b = mode_signed ? {{16{opb[15]}}, opb} : {16'h0000, opb};
    alu_r = 32'h0;
    case (op)
      OP_ADD:  alu_r = ext_a + ext_b;
      OP_SUB:  alu_r = ext_a - ext_b;
      default: alu_r = ext_a * ext_b;
    endcase
  end

  function automatic logic [7:0] tx_char(input logic [3:0] idx, input logic [31:0] r);
    logic [31:0] sh;
    logic [7:0]  c;
    sh = r >> (5'd28 - {idx[2:0], 2'b00});
    if (idx == 4'd8)      c = ASC_CR;
    else if (idx == 4'd9) c = ASC_LF;
    else                  c = nib2hex(sh[3:0]);
    return c;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pstate      <= ST_WAIT_I;
      mode_signed <= 1'b0;
      op          <= OP_ADD;
      opa         <= 16'h0000;
      opb         <= 16'h0000;
      result      <= 32'h0;
    end else if (tx_busy) begin
      pstate <= ST_WAIT_I;
    end else if (rx_byte.tvalid) begin
      if (rx_byte.tdata == ASC_I) begin
        pstate <= ST_SP1;
      end else begin
        // Anything the current state does not accept discards the frame
        pstate <= ST_WAIT_I;
        case (pstate)
          ST_SP1:  if (rx_byte.tdata == ASC_SP) pstate <= ST_MODE;
          ST_MODE: begin
            if (rx_byte.tdata == ASC_S) begin
              mode_signed <= 1'b1;
              pstate      <= ST_SP2;
            end else if (rx_byte.tdata == ASC_U) begin
              mode_signed <= 1'b0;
              pstate      <= ST_SP2;
            end
          end
          ST_SP2:  if (rx_byte.tdata == ASC_SP) pstate <= ST_A0;
          ST_A0, ST_A1, ST_A2, ST_A3: begin
            if (rx_nib.valid) begin
              opa    <= {opa[11:0], rx_nib.nib};
              pstate <= parse_state_e'(pstate + 4'd1);
            end
          end
          ST_OP: begin
            if (rx_byte.tdata == ASC_PLUS) begin
              op     <= OP_ADD;
              pstate <= ST_B0;
            end else if (rx_byte.tdata == ASC_MINUS) begin
              op     <= OP_SUB;
              pstate <= ST_B0;
            end else if (rx_byte.tdata == ASC_STAR) begin
              op     <= OP_MUL;
              pstate <= ST_B0;
            end
          end
          ST_B0, ST_B1, ST_B2, ST_B3: begin
            if (rx_nib.valid) begin
              opb    <= {opb[11:0], rx_nib.nib};
              pstate <= parse_state_e'(pstate + 4'd1);
            end
          end
          ST_EQ:   if (tx_start) result <= alu_r;
          default: pstate <= ST_WAIT_I;
        endcase
      end
    end
  end

  // tx_frame holds {stop, data, start}; bit 0 is always the one currently on txd
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_busy     <= 1'b0;
      tx_cnt      <= '0;
      tx_bit      <= 4'd0;
      tx_byte_idx <= 4'd0;
      tx_frame    <= 10'h3FF;
      txd         <= 1'b1;
    end else if (tx_start) begin
      tx_busy     <= 1'b1;
      tx_cnt      <= '0;
      tx_bit      <= 4'd0;
      tx_byte_idx <= 4'd0;
      tx_frame    <= {1'b1, tx_char(4'd0, alu_r), 1'b0};
      txd         <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          if (tx_byte_idx == 4'd9) begin
            tx_busy <= 1'b0;
            txd     <= 1'b1;
          end else begin
            tx_byte_idx <= tx_byte_idx + 4'd1;
            tx_bit      <= 4'd0;
            tx_frame    <= {1'b1, tx_char(tx_byte_idx + 4'd1, result), 1'b0};
            txd         <= 1'b0;
          end
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          tx_frame <= {1'b1, tx_frame[9:1]};
          txd      <= tx_frame[1];
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_calc_top.sv
// tb/tb_uart_calc_top.sv - Scoreboard bench for uart_calc_top with directed and random commands
module tb_uart_calc_top;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic rxd = 1'b1;
  logic txd;

  int tests = 0;
  int failed = 0;
  int low_cycles = 0;
  logic [7:0] exp_q[$];

  uart_calc_if mon ();

  uart_calc_top #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rxd   (rxd),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial forever begin
    @(negedge clk);
    if (n_rst && txd !== 1'b1) low_cycles++;
  end

  // Serial decoder for txd: forwards each good byte onto the monitor stream
  logic       dec_ok;
  logic [7:0] dec_data;
  initial begin
    mon.tvalid = 1'b0;
    mon.tdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (n_rst && txd === 1'b0) begin
        dec_ok = 1'b1;
        for (int k = 0; k < CPB / 2; k++) begin
          @(negedge clk);
          if (!n_rst) dec_ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (!n_rst) dec_ok = 1'b0;
          end
          dec_data[i] = txd;
        end
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk);
          if (!n_rst) dec_ok = 1'b0;
        end
        if (dec_ok) begin
          tests++;
          if (txd !== 1'b1) begin
            failed++;
            $display("FAIL tx_stop_bit: got %b, expected 1", txd);
          end
          mon.tdata  = dec_data;
          mon.tvalid = 1'b1;
          @(negedge clk);
          mon.tvalid = 1'b0;
        end
      end
    end
  end

  logic [7:0] exp_b;
  initial forever begin
    @(posedge clk);
    if (mon.tvalid) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL tx_byte: got 0x%02h, expected no byte (nothing pending)", mon.tdata);
      end else begin
        exp_b = exp_q.pop_front();
        if (mon.tdata !== exp_b) begin
          failed++;
          $display("FAIL tx_byte: got 0x%02h, expected 0x%02h", mon.tdata, exp_b);
        end
      end
    end
  end

  function automatic logic [31:0] calc(input bit sgn, input byte opc,
                                       input logic [15:0] a, input logic [15:0] b);
    longint va, vb, r;
    va = sgn ? longint'($signed(a)) : longint'(a);
    vb = sgn ? longint'($signed(b)) : longint'(b);
    if (opc == "+")      r = va + vb;
    else if (opc == "-") r = va - vb;
    else                 r = va * vb;
    return r[31:0];
  endfunction

  function automatic string hex4(input logic [15:0] v);
    string s;
    int    n;
    byte   c;
    s = "";
    for (int i = 3; i >= 0; i--) begin
      n = int'((v >> (4 * i)) & 16'hF);
      if (n < 10)                    c = byte'(48 + n);
      else if ($urandom_range(0, 1)) c = byte'(65 + n - 10);
      else                           c = byte'(97 + n - 10);
      s = $sformatf("%s%c", s, c);
    end
    return s;
  endfunction

  task automatic expect_reply(input logic [31:0] r);
    int n;
    for (int i = 7; i >= 0; i--) begin
      n = int'((r >> (4 * i)) & 32'hF);
      exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(55 + n));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = !bad_stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    if (bad_stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int bad_idx);
    @(negedge clk);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], i == bad_idx);
  endtask

  task automatic check_latency(input string name);
    int k;
    k = 0;
    while (txd !== 1'b0 && k < 8) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (txd !== 1'b0) begin
      failed++;
      $display("FAIL tx_latency %s: txd=%b after '=', expected start bit 0", name, txd);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 120 * CPB) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL reply_timeout %s: %0d bytes still pending, expected 0", name, exp_q.size());
    end
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic check_silence(input string name);
    repeat (30 * CPB) @(negedge clk);
    tests++;
    if (low_cycles != 0) begin
      failed++;
      $display("FAIL silence %s: txd low for %0d cycles, expected 0", name, low_cycles);
    end
  endtask

  task automatic run_cmd(input string s, input logic [31:0] r);
    expect_reply(r);
    send_str(s, -1);
    check_latency(s);
    drain(s);
  endtask

  bit         r_sgn;
  byte        r_op;
  logic [15:0] r_a, r_b;
  logic [15:0] edge_vals[4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
  string       cmd;
  int          k;

  initial begin
    repeat (4) @(negedge clk);
    tests++;
    if (txd !== 1'b1) begin
      failed++;
      $display("FAIL reset_txd: got %b, expected 1", txd);
    end
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (txd !== 1'b1) begin
      failed++;
      $display("FAIL idle_txd: got %b, expected 1", txd);
    end

    run_cmd("I S fff5+0004=", 32'hFFFFFFF9);
    run_cmd("I S fff3-0004=", 32'hFFFFFFEF);
    run_cmd("I U fff5+0004=", 32'h0000FFF9);
    run_cmd("I S FFFE*0003=", 32'hFFFFFFFA);
    run_cmd("I U FFFF*FFFF=", 32'hFFFE0001);

    low_cycles = 0;
    send_str("I X 0001+0001=", -1);
    check_silence("bad_mode");
    run_cmd("I U 0001+0002=", 32'h00000003);

    low_cycles = 0;
    send_str("I U 0001+0002=", 8);
    check_silence("framing_error");

    // Second command arrives while the first reply is still going out
    expect_reply(32'h00000002);
    send_str("I U 0001+0001=", -1);
    check_latency("busy_first");
    send_str("I U 0005+0005=", -1);
    drain("busy_first");
    low_cycles = 0;
    check_silence("busy_ignored");

    expect_reply(32'h00001235);
    send_str("I U 1234+0001=", -1);
    k = 0;
    while (exp_q.size() > 7 && k < 60 * CPB) begin
      @(negedge clk);
      k++;
    end
    repeat (3 * CPB + 2) @(negedge clk);
    n_rst = 1'b0;
    #1;
    tests++;
    if (txd !== 1'b1) begin
      failed++;
      $display("FAIL reset_mid_tx: txd=%b, expected 1", txd);
    end
    repeat (3) @(negedge clk);
    exp_q.delete();
    n_rst = 1'b1;
    repeat (14 * CPB) @(negedge clk);
    run_cmd("I S 8000-0001=", 32'hFFFF7FFF);

    for (int t = 0; t < 8; t++) begin
      r_sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       r_op = "+";
        1:       r_op = "-";
        default: r_op = "*";
      endcase
      r_a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      r_b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      cmd = $sformatf("I %s %s%c%s=", r_sgn ? "S" : "U", hex4(r_a), r_op, hex4(r_b));
      run_cmd(cmd, calc(r_sgn, r_op, r_a, r_b));
    end

    tests++;
    if (exp_q.size() != 0 || txd !== 1'b1) begin
      failed++;
      $display("FAIL final_idle: pending=%0d txd=%b, expected 0 and 1", exp_q.size(), txd);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_calc_top.md
Name: uart_calc_top

Overview:
- UART-driven 16-bit hex calculator.
- Receives an ASCII command frame on rxd (8N1, CLKS_PER_BIT clocks per bit), parses two 4-digit hex operands and an operator, and computes the result in signed or unsigned mode.
- Transmits the 32-bit result on txd as 8 uppercase hex digits followed by CR LF.
- Top-level block of the UART calculator project.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (same value for RX and TX).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- rxd  in  1  UART serial input; idle high.
- txd  out  1  UART serial output; idle high.

Behaviour:
- Clocking/reset: one clock (clk); reset asynchronous active-low (n_rst). Reset: txd=1, RX/TX/parser idle, operand/result registers 0.
- RX input sync: rxd through 2-flop synchronizer.
- RX start: falling edge (1->0) starts a frame. Start bit re-checked at CLKS_PER_BIT/2; if high, treat as a glitch and return to idle.
- RX data: 8 data bits sampled LSB first, each CLKS_PER_BIT after the previous sample.
- RX stop: sampled once more. Stop=0 is a framing error; byte dropped, no byte_valid.
- RX output: byte_valid pulses 1 clk with the data byte.
- Parser states, in order:
  - WAIT_I: accepts 'I' (0x49).
  - SP1: accepts ' ' (0x20).
  - MODE: 'S' (0x53) = signed, 'U' (0x55) = unsigned.
  - SP2: accepts ' '.
  - A0-A3: operand A, MSD first.
  - OP: '+' (0x2B), '-' (0x2D) or '*' (0x2A).
  - B0-B3: operand B, MSD first.
  - EQ: accepts '=' (0x3D).
- Hex digits: accept 0-9, a-f, A-F.
- Invalid byte in any state: discard frame, go to WAIT_I, no output. Exception: 'I' received in a non-WAIT_I state restarts at SP1.
- Compute, on '=': 32-bit result R.
  - A and B are sign-extended (S) or zero-extended (U) to 32 bits.
  - R = A+B, A-B or A*B, mod 2^32.
  - Signed multiply uses signed 16x16 -> 32.
- TX: the first start bit goes out within 4 clks after '=' is accepted.
- TX frame: 10 bytes, 8N1, LSB first, each bit CLKS_PER_BIT clks. Bytes: R[31:28] .. R[3:0] as uppercase ASCII hex ('0'-'9', 'A'-'F'), then 0x0D, 0x0A.
- TX spacing: no idle gap required between bytes. Total transmit = 10*10*CLKS_PER_BIT clks.
- RX while transmitting: RX keeps running, but the parser ignores bytes while TX is busy and stays in WAIT_I. The next command is accepted after the final LF stop bit.
- Reset mid-frame (RX or TX): immediate abort; txd=1.

Decomposition:
- Package uart_calc_pkg holds:
  - ASCII constants: I, SP, S, U, +, -, *, =, CR, LF.
  - Parser state enum.
  - Helpers: hex2nib (returns valid flag + nibble) and nib2hex.
- One sub-module: uart_rx (synchronizer, bit timing, byte_valid/data out).
- TX shift logic, parser and ALU stay in uart_calc_top.

Test Plan:
- "I S fff5+0004=" -> txd sends "FFFFFFF9\r\n" (signed -11+4 = -7).
- "I S fff3-0004=" sent after the previous reply completes -> "FFFFFFEF\r\n" (signed -13-4 = -17).
- "I U fff5+0004=" -> "0000FFF9\r\n".
- "I S FFFE*0003=" -> "FFFFFFFA\r\n".
- "I U FFFF*FFFF=" -> "FFFE0001\r\n".
- "I X 0001+0001=" (invalid mode), then "I U 0001+0002=" -> first frame produces no output (txd stays 1); second -> "00000003\r\n".
- Byte with stop bit forced 0 inside a frame -> byte dropped; frame aborts once the next byte fails to parse; no txd activity.
- n_rst pulsed low during a TX byte -> txd=1 immediately; the next valid command is processed normally.
